eib_stack: RTL and testbench

Parametrised external interrupt block for the tenyr core. It latches up to IRQ_COUNT external interrupt lines, in level or edge mode per line, and masks them through a hardware stack of interrupt-mask registers. It raises `trap` to the core and keeps a return-address stack that handlers push and pop over the memory bus. It occupies the top 16-bit page of the address space (addr[31:16] == BASE).

---
 rtl/eib_stack.sv | 152 +++++++++++++++
 tb/tb_eib_stack.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eib_stack.sv
// External interrupt block: level/edge capture, stacked masks,
// return-address stack, and trap generation for the tenyr core.
module eib_stack #(
  parameter int          IRQ_COUNT = 32,
  parameter int          DEPTH     = 8,
  parameter logic [15:0] BASE      = 16'hffff
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 strobe,
  input  logic                 rw,
  input  logic [31:0]          addr,
  inout  wire  [31:0]          data,
  input  logic [IRQ_COUNT-1:0] irq,
  output logic                 trap
);

  localparam int DW = $clog2(DEPTH);

  localparam logic [15:0] OFF_ISR    = 16'hfff0;
  localparam logic [15:0] OFF_IMR    = 16'hfff1;
  localparam logic [15:0] OFF_MODE   = 16'hfff2;
  localparam logic [15:0] OFF_STATUS = 16'hfff3;
  localparam logic [15:0] OFF_CAUSE  = 16'hfff4;
  localparam logic [15:0] OFF_RA     = 16'hffff;

  typedef logic [IRQ_COUNT-1:0] vec_t;

  vec_t          irq_q, irq_d;
  vec_t          prev_q, prev_d;
  vec_t          isr_q, isr_d;
  vec_t          mode_q, mode_d;
  vec_t          imrs_q [DEPTH];
  vec_t          imrs_d [DEPTH];
  logic [31:0]   rets_q [DEPTH];
  logic [31:0]   rets_d [DEPTH];
  logic [DW-1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic          hit, rd, wr;
  logic [15:0]   off;
  vec_t          imr_top, act, clr, rise;
  logic [DW-1:0] up;
  logic [31:0]   cause, rdata;

  assign hit     = strobe && (addr[31:16] == BASE);
  assign rd      = hit && !rw;
  assign wr      = hit && rw;
  assign off     = addr[15:0];
  assign imr_top = imrs_q[depth_q];
  assign act     = isr_q & imr_top;
  assign up      = depth_q + 1'b1;
  assign trap    = |act;
  assign data    = rd ? rdata : 'z;

  // Lowest-numbered pending and enabled line, all ones when none.
  always_comb begin
    cause = '1;
    for (int i = IRQ_COUNT - 1; i >= 0; i--) begin
      if (act[i]) cause = 32'(i);
    end
  end

  // Zero-wait read mux; unmapped offsets read zero.
  always_comb begin
    rdata = '0;
    case (off)
      OFF_ISR:    rdata[IRQ_COUNT-1:0] = isr_q;
      OFF_IMR:    rdata[IRQ_COUNT-1:0] = imr_top;
      OFF_MODE:   rdata[IRQ_COUNT-1:0] = mode_q;
      OFF_STATUS: begin
        rdata[DW-1:0] = depth_q;
        rdata[8]      = ovf_q;
        rdata[9]      = unf_q;
      end
      OFF_CAUSE:  rdata = cause;
      OFF_RA:     if (depth_q != '0) rdata = rets_q[depth_q];
      default:    rdata = '0;
    endcase
  end

  // Next state: capture, bus writes, push and pop.
  always_comb begin
    irq_d   = irq;
    prev_d  = irq_q;
    mode_d  = mode_q;
    imrs_d  = imrs_q;
    rets_d  = rets_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    clr     = '0;
    rise    = irq_q & ~prev_q;
    if (wr) begin
      case (off)
        OFF_ISR:    clr = data[IRQ_COUNT-1:0] & mode_q;
        OFF_IMR:    imrs_d[depth_q] = data[IRQ_COUNT-1:0];
        OFF_MODE:   mode_d = data[IRQ_COUNT-1:0];
        OFF_STATUS: begin
          ovf_d = 1'b0;
          unf_d = 1'b0;
        end
        OFF_RA: begin
          if (depth_q == DW'(DEPTH - 1)) begin
            ovf_d = 1'b1;
          end else begin
            depth_d    = up;
            rets_d[up] = data;
            imrs_d[up] = imr_top;
          end
        end
        default: ;
      endcase
    end
    if (rd && off == OFF_RA) begin
      if (depth_q == '0) unf_d = 1'b1;
      else               depth_d = depth_q - 1'b1;
    end
    // Edge bits: set beats clear in the same cycle.
    isr_d = (mode_q & ((isr_q & ~clr) | rise))
          | (~mode_q & irq_q);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_q   <= '0;
      prev_q  <= '0;
      isr_q   <= '0;
      mode_q  <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        imrs_q[i] <= '1;
        rets_q[i] <= '0;
      end
    end else begin
      irq_q   <= irq_d;
      prev_q  <= prev_d;
      isr_q   <= isr_d;
      mode_q  <= mode_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      imrs_q  <= imrs_d;
      rets_q  <= rets_d;
    end
  end

endmodule

// File: tb/tb_eib_stack.sv
// Randomized scoreboard bench for eib_stack against a
// queue-based reference model of the interrupt block.
module tb_eib_stack;

  localparam int          N     = 4;
  localparam int          DEPTH = 8;
  localparam logic [15:0] BASE  = 16'hffff;

  localparam logic [15:0] ISR    = 16'hfff0;
  localparam logic [15:0] IMR    = 16'hfff1;
  localparam logic [15:0] MODE   = 16'hfff2;
  localparam logic [15:0] STATUS = 16'hfff3;
  localparam logic [15:0] CAUSE  = 16'hfff4;
  localparam logic [15:0] RA     = 16'hffff;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         strobe;
  logic         rw;
  logic [31:0]  addr;
  logic [N-1:0] irq;
  wire  [31:0]  data;
  wire          trap;
  logic         oe;
  logic [31:0]  dout;

  assign data = oe ? dout : 'z;
  always #5 clk = ~clk;

  eib_stack #(.IRQ_COUNT(N), .DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk(clk), .reset_n(reset_n), .strobe(strobe), .rw(rw),
    .addr(addr), .data(data), .irq(irq), .trap(trap)
  );

  typedef struct {
    logic [31:0] d;
    logic        t;
    string       n;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model
  logic [N-1:0] m_isr, m_mode, m_sync, m_prev;
  logic [31:0]  m_ra[$];
  logic [N-1:0] m_imr[$];
  bit           m_ovf, m_unf;
  logic [N-1:0] cur_irq;

  function automatic void m_reset();
    m_isr = '0; m_mode = '0; m_sync = '0; m_prev = '0;
    m_ra.delete();
    m_imr.delete();
    m_imr.push_back('1);
    m_ovf = 0; m_unf = 0;
  endfunction

  function automatic logic [N-1:0] m_top();
    return m_imr[m_imr.size() - 1];
  endfunction

  function automatic logic m_trap();
    return |(m_isr & m_top());
  endfunction

  function automatic logic [31:0] m_read(logic [15:0] o);
    logic [31:0] r;
    logic [N-1:0] a;
    r = 0;
    a = m_isr & m_top();
    case (o)
      ISR:    r = 32'(m_isr);
      IMR:    r = 32'(m_top());
      MODE:   r = 32'(m_mode);
      STATUS: r = 32'(m_ra.size()) + (m_ovf ? 32'h100 : 0)
                + (m_unf ? 32'h200 : 0);
      CAUSE: begin
        r = 32'hffffffff;
        for (int i = 0; i < N; i++)
          if (a[i] && r == 32'hffffffff) r = i;
      end
      RA:     r = (m_ra.size() > 0) ? m_ra[m_ra.size() - 1] : 0;
      default: r = 0;
    endcase
    return r;
  endfunction

  function automatic void m_commit(bit hit, bit w, logic [15:0] o,
                                   logic [31:0] wd, logic [N-1:0] iv);
    logic [N-1:0] clr, old_mode, nisr;
    clr = 0;
    old_mode = m_mode;
    if (hit && w) begin
      case (o)
        ISR:    clr = wd[N-1:0];
        IMR:    m_imr[m_imr.size() - 1] = wd[N-1:0];
        MODE:   m_mode = wd[N-1:0];
        STATUS: begin m_ovf = 0; m_unf = 0; end
        RA: begin
          if (m_ra.size() < DEPTH - 1) begin
            m_imr.push_back(m_top());
            m_ra.push_back(wd);
          end else m_ovf = 1;
        end
        default: ;
      endcase
    end
    if (hit && !w && o == RA) begin
      if (m_ra.size() > 0) begin
        void'(m_ra.pop_back());
        void'(m_imr.pop_back());
      end else m_unf = 1;
    end
    for (int i = 0; i < N; i++) begin
      if (old_mode[i])
        nisr[i] = (m_isr[i] && !clr[i]) || (m_sync[i] && !m_prev[i]);
      else
        nisr[i] = m_sync[i];
    end
    m_isr  = nisr;
    m_prev = m_sync;
    m_sync = iv;
  endfunction

  // One bus cycle, entered and left 1 time unit after a rising edge.
  task automatic step(bit stb, bit w, logic [15:0] page,
                      logic [15:0] o, logic [31:0] wd,
                      bit lit, logic [31:0] lv);
    bit hit;
    exp_t e;
    hit = stb && page == BASE;
    strobe = stb; rw = w; addr = {page, o};
    irq = cur_irq; oe = stb && w; dout = wd;
    if (hit && !w) begin
      e.d = lit ? lv : m_read(o);
      e.t = m_trap();
      e.n = $sformatf("rd_%h", o);
      sb.push_back(e);
    end
    @(posedge clk);
    m_commit(hit, w, o, wd, cur_irq);
    #1;
    strobe = 0; oe = 0;
  endtask

  task automatic wr(logic [15:0] o, logic [31:0] wd);
    step(1, 1, BASE, o, wd, 0, 0);
  endtask
  task automatic rd(logic [15:0] o);
    step(1, 0, BASE, o, 0, 0, 0);
  endtask
  task automatic rdx(logic [15:0] o, logic [31:0] lv);
    step(1, 0, BASE, o, 0, 1, lv);
  endtask

  // Monitor: every active read pops one expectation.
  always @(negedge clk) begin
    if (reset_n && strobe && !rw && addr[31:16] == BASE) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: read with no expectation");
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (data !== e.d) begin
          errors++;
          $display("FAIL %s data got %h want %h", e.n, data, e.d);
        end
        checks++;
        if (trap !== e.t) begin
          errors++;
          $display("FAIL %s trap got %b want %b", e.n, trap, e.t);
        end
      end
    end
  end

  initial begin
    logic [15:0] offs [7];
    offs = '{ISR, IMR, MODE, STATUS, CAUSE, RA, 16'h0010};
    reset_n = 0; strobe = 0; rw = 0; addr = 0;
    irq = 0; oe = 0; dout = 0; cur_irq = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1;

    rdx(STATUS, 32'h0);
    rdx(ISR, 32'h0);
    rdx(IMR, 32'hf);

    // Level line 3: trap two clocks after irq
    cur_irq = 4'b1000;
    rd(CAUSE); rd(CAUSE); rd(CAUSE);
    rdx(CAUSE, 32'd3);
    cur_irq = 0;
    rd(CAUSE); rd(CAUSE); rd(CAUSE);
    rdx(CAUSE, 32'hffffffff);

    // Edge line 0
    wr(MODE, 32'h1);
    cur_irq = 4'b0001; rd(ISR);
    cur_irq = 0; rd(ISR); rd(ISR);
    rdx(ISR, 32'h1);
    wr(ISR, 32'h1);
    rdx(ISR, 32'h0);
    cur_irq = 4'b0001; rd(ISR);
    cur_irq = 0; wr(ISR, 32'h1);
    rdx(ISR, 32'h1);
    wr(ISR, 32'h1);
    rdx(ISR, 32'h0);

    // Stacked masks and return addresses
    wr(MODE, 32'h0);
    cur_irq = 4'b0100;
    rd(CAUSE); rd(CAUSE);
    wr(RA, 32'h100);
    wr(IMR, 32'h0);
    wr(RA, 32'h200);
    rdx(STATUS, 32'h2);
    rdx(RA, 32'h200);
    rdx(RA, 32'h100);
    rdx(IMR, 32'hf);

    // Overflow and underflow
    for (int i = 0; i < 8; i++) wr(RA, $urandom);
    rdx(STATUS, 32'h107);
    wr(STATUS, 32'h0);
    for (int i = 0; i < 7; i++) rd(RA);
    rdx(RA, 32'h0);
    rdx(STATUS, 32'h200);
    wr(STATUS, 32'h0);
    rdx(STATUS, 32'h0);

    // Unimplemented upper bits read zero
    wr(IMR, 32'hffffffff);
    rdx(IMR, 32'hf);
    wr(MODE, 32'hfffffff0);
    rdx(MODE, 32'h0);

    // Accesses outside the page leave state alone
    wr(RA, 32'h5);
    step(1, 1, 16'h1234, IMR, 32'h0, 0, 0);
    step(1, 0, 16'h1234, RA, 32'h0, 0, 0);
    rdx(STATUS, 32'h1);
    rdx(IMR, 32'hf);
    rd(RA);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      logic [15:0] o;
      logic [15:0] pg;
      bit w;
      if ($urandom_range(0, 3) == 0) cur_irq = N'($urandom);
      o  = offs[$urandom_range(0, 6)];
      pg = ($urandom_range(0, 15) == 0) ? 16'h7000 : BASE;
      w  = $urandom_range(0, 2) == 0;
      step($urandom_range(0, 4) != 0, w, pg, o, $urandom, 0, 0);
    end

    // Asynchronous reset in the middle of a push
    wr(IMR, 32'hf);
    wr(MODE, 32'h0);
    cur_irq = 4'b0010;
    wr(RA, 32'h77);
    rd(CAUSE); rd(CAUSE);
    strobe = 1; rw = 1; addr = {BASE, RA};
    oe = 1; dout = 32'h99;
    #2 reset_n = 0;
    #1;
    checks++;
    if (trap !== 1'b0) begin
      errors++;
      $display("FAIL reset_trap got %b want 0", trap);
    end
    strobe = 0; oe = 0; cur_irq = 0; irq = 0;
    m_reset();
    @(posedge clk);
    #1 reset_n = 1;
    rdx(STATUS, 32'h0);
    rdx(IMR, 32'hf);
    rdx(ISR, 32'h0);

    @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_left got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
